text_writer: RTL
================

Name: text_writer

Overview:
- Terminal-style character writer that drives the write side of the 80x30 text RAM feeding the VGA glyph renderer.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor.
- Printable bytes are written at the cursor. Control bytes (CR, LF, BS, FF) move the cursor or clear the screen.
- Typical upstream source is a UART receiver or a soft CPU.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, RAM address width; COLS*ROWS must be <= 2**ADDR_W
- FILL_CHAR, 8'h20, byte written by clear and backspace

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a byte
- in_data  in  8  character or control byte
- in_ready  out  1  block can accept a byte this cycle
- ram_we  out  1  write strobe to text RAM
- ram_addr  out  ADDR_W  text RAM address = row*COLS + col
- ram_data  out  8  byte to write
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- busy  out  1  clear sweep in progress

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_data=0, cursor_col=0, cursor_row=0, busy=0, state=IDLE. in_ready goes high on the first edge after reset deassertion.
- All outputs are registered except in_ready. in_ready = (state==IDLE) && rst_n.
- A byte transfers on a clock edge where in_valid && in_ready. Every accepted byte is consumed, including ignored ones.
- Keep a linear address register lin = row*COLS+col, updated incrementally alongside col/row. No multiplier is allowed.
- State machine: IDLE and CLEAR.
- IDLE, printable byte (0x20..0x7E):
  - Next cycle: ram_we=1, ram_addr=lin, ram_data=byte.
  - Cursor advances by one column.
  - At col==COLS-1: col wraps to 0 and row increments.
  - At row==ROWS-1 with col wrap: row wraps to 0 and lin wraps to 0. There is no scrolling.
- IDLE, 0x0D (CR): col=0; lin reduced by old col. No write.
- IDLE, 0x0A (LF): col=0, row+1 with wrap to 0 after ROWS-1. No write.
- IDLE, 0x08 (BS):
  - If col>0: col-1, then next cycle ram_we=1, ram_addr=new lin, ram_data=FILL_CHAR.
  - If col==0: no-op, no write.
- IDLE, 0x0C (FF): enter CLEAR, busy=1, in_ready=0.
- Any other byte: consumed, no write, cursor unchanged.
- CLEAR:
  - One write per cycle: ram_we=1, ram_data=FILL_CHAR, ram_addr=0,1,...,COLS*ROWS-1. That is 2400 consecutive writes for the defaults.
  - First write occurs the cycle after FF is accepted.
  - In the cycle after the last write: ram_we=0, busy=0, cursor=(0,0), lin=0, state=IDLE.
  - in_ready is high in that same cycle.
- ram_we is a single-cycle pulse per write, except during CLEAR where it stays high continuously. Back-to-back printable bytes give back-to-back writes, one per cycle (full throughput).
- When ram_we=0, ram_addr and ram_data hold their last values.
- cursor_col/cursor_row reflect the post-update cursor in the same cycle that the corresponding ram_we is presented.
- Reset asserted mid-CLEAR aborts the sweep immediately. The RAM is left partially cleared; outputs return to reset values.
- in_data is sampled only on the accepting edge. in_valid while in_ready=0 has no effect, and the source must hold the byte.

Decomposition:
- Shared package (text_pkg) holds:
  - the COLS/ROWS/ADDR_W defaults
  - control-byte constants CHR_BS=8'h08, CHR_LF=8'h0A, CHR_FF=8'h0C, CHR_CR=8'h0D
  - printable range bounds 8'h20/8'h7E
- One natural sub-module, text_cursor: holds col/row/lin with advance, newline, carriage-return and back operations, plus wrap logic.
- text_writer keeps the FSM, the clear counter and the RAM port registers.

Test Plan:
- Reset, then send "A" (0x41) -> one cycle later ram_we=1, ram_addr=0, ram_data=0x41; cursor=(1,0).
- Send 80 bytes of 0x42 from (0,0) -> 80 writes to addr 0..79 with no gap when in_valid is held; cursor=(0,1); next byte writes addr 80.
- Cursor at (79,29), send 0x43 -> write at addr 2399, then cursor=(0,0). Subsequent 0x44 writes addr 0.
- Bytes "AB", 0x08, "C" -> writes 0x41@0, 0x42@1, 0x20@1, 0x43@1. A further BS pair at col 0 produces no write.
- Send 0x0C -> in_ready low, 2400 consecutive writes of 0x20 to addr 0..2399, busy high throughout. Then busy=0, cursor=(0,0), in_ready=1.
- Pulse rst_n low mid-clear (after 1000 writes) -> ram_we drops asynchronously, all outputs zero; after release, "Z" writes addr 0.

Source files
------------

// File: rtl/text_pkg.sv
// Shared definitions for the text writer: geometry defaults, control-byte
// codes, printable range, state/operation enums and a printable-test helper.
package text_pkg;

    localparam int          COLS_DEF   = 80;
    localparam int          ROWS_DEF   = 30;
    localparam int          ADDR_W_DEF = 12;
    localparam logic [7:0]  FILL_DEF   = 8'h20;

    localparam logic [7:0]  CHR_BS     = 8'h08;
    localparam logic [7:0]  CHR_LF     = 8'h0A;
    localparam logic [7:0]  CHR_FF     = 8'h0C;
    localparam logic [7:0]  CHR_CR     = 8'h0D;

    localparam logic [7:0]  PRINT_LO   = 8'h20;
    localparam logic [7:0]  PRINT_HI   = 8'h7E;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_t;

    // Cursor operations requested by the writer for the next edge.
    typedef enum logic [2:0] {
        CUR_NONE = 3'd0,
        CUR_ADV  = 3'd1,
        CUR_LF   = 3'd2,
        CUR_CR   = 3'd3,
        CUR_BS   = 3'd4,
        CUR_HOME = 3'd5
    } cur_op_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor tracker for the text writer. Holds column, row and the linear RAM
// address lin = row*COLS + col, all updated incrementally (no multiplier).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   op           operation applied on the next rising edge
//   col, row     current cursor position
//   lin          current linear address of the cursor cell
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cur_op_t           op,
    output logic [6:0]        col,
    output logic [4:0]        row,
    output logic [ADDR_W-1:0] lin
);

    localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [ADDR_W-1:0] col_a;
    assign col_a = ADDR_W'(col);

    // Cursor register: applies the requested operation with wrap handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= 7'd0;
            row <= 5'd0;
            lin <= '0;
        end else begin
            case (op)
                CUR_ADV: begin
                    if (col == COL_LAST) begin
                        col <= 7'd0;
                        if (row == ROW_LAST) begin
                            // Bottom-right cell: wrap to the top, no scrolling.
                            row <= 5'd0;
                            lin <= '0;
                        end else begin
                            row <= row + 5'd1;
                            lin <= lin + ONE;
                        end
                    end else begin
                        col <= col + 7'd1;
                        lin <= lin + ONE;
                    end
                end
                CUR_LF: begin
                    col <= 7'd0;
                    if (row == ROW_LAST) begin
                        row <= 5'd0;
                        lin <= '0;
                    end else begin
                        row <= row + 5'd1;
                        // Start of the next row: drop the column, add one row.
                        lin <= lin - col_a + COLS_A;
                    end
                end
                CUR_CR: begin
                    col <= 7'd0;
                    lin <= lin - col_a;
                end
                CUR_BS: begin
                    if (col != 7'd0) begin
                        col <= col - 7'd1;
                        lin <= lin - ONE;
                    end else begin
                        col <= col;
                        lin <= lin;
                    end
                end
                CUR_HOME: begin
                    col <= 7'd0;
                    row <= 5'd0;
                    lin <= '0;
                end
                default: begin
                    col <= col;
                    row <= row;
                    lin <= lin;
                end
            endcase
        end
    end

endmodule

// File: rtl/text_writer.sv
// Terminal-style character writer driving the write port of the text RAM.
// Accepts bytes over valid/ready, writes printable bytes at the cursor,
// interprets CR/LF/BS and sweeps the whole screen with FILL_CHAR on FF.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   in_valid, in_data      input byte stream
//   in_ready               byte can be accepted this cycle (combinational)
//   ram_we/addr/data       registered text RAM write port
//   cursor_col/cursor_row  registered cursor position
//   busy                   clear sweep in progress
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS      = COLS_DEF,
    parameter int         ROWS      = ROWS_DEF,
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter logic [7:0] FILL_CHAR = FILL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    // One extra bit so the cell count fits even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(COLS * ROWS);

    wr_state_t         state, state_nxt;
    cur_op_t           cur_op;
    logic [ADDR_W-1:0] lin;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        data_nxt;
    logic              busy_nxt;
    logic              accept;

    assign in_ready = (state == ST_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    text_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (cur_op),
        .col   (cursor_col),
        .row   (cursor_row),
        .lin   (lin)
    );

    // Next-state, cursor operation and next RAM port values.
    always_comb begin
        state_nxt   = state;
        cur_op      = CUR_NONE;
        clr_cnt_nxt = clr_cnt;
        we_nxt      = 1'b0;
        addr_nxt    = ram_addr;
        data_nxt    = ram_data;
        busy_nxt    = busy;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        // Write at the current cell, then step the cursor.
                        we_nxt   = 1'b1;
                        addr_nxt = lin;
                        data_nxt = in_data;
                        cur_op   = CUR_ADV;
                    end else begin
                        case (in_data)
                            CHR_CR: cur_op = CUR_CR;
                            CHR_LF: cur_op = CUR_LF;
                            CHR_BS: begin
                                if (cursor_col != 7'd0) begin
                                    // Erase the cell the cursor moves back onto.
                                    cur_op   = CUR_BS;
                                    we_nxt   = 1'b1;
                                    addr_nxt = lin - ADDR_W'(1);
                                    data_nxt = FILL_CHAR;
                                end else begin
                                    cur_op = CUR_NONE;
                                end
                            end
                            CHR_FF: begin
                                state_nxt   = ST_CLEAR;
                                busy_nxt    = 1'b1;
                                clr_cnt_nxt = '0;
                            end
                            default: cur_op = CUR_NONE;
                        endcase
                    end
                end else begin
                    cur_op = CUR_NONE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CELLS) begin
                    // Sweep done: home the cursor and reopen the input.
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    cur_op    = CUR_HOME;
                end else begin
                    we_nxt      = 1'b1;
                    addr_nxt    = clr_cnt[ADDR_W-1:0];
                    data_nxt    = FILL_CHAR;
                    clr_cnt_nxt = clr_cnt + (ADDR_W + 1)'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, clear counter and registered RAM port / busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            ram_we   <= we_nxt;
            ram_addr <= addr_nxt;
            ram_data <= data_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
